// File: rtl/hex_pkg.sv
// Shared types and constants for the multiplexed hex 7-segment scanner.
package hex_pkg;

  typedef struct packed {
    logic       blank;
    logic       dp;
    logic [3:0] val;
  } dig_rec_t;

  // Active-high "no segments lit" pattern, bits g..a.
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Active-high hex font, entry n drives digit n, bits g..a.
  localparam logic [15:0][6:0] FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex_font.sv
// Combinational nibble to active-high 7-segment pattern decoder.
module hex_font
  import hex_pkg::*;
(
  input  logic [3:0] i_val,
  output logic [6:0] o_seg_c
);

  assign o_seg_c = FONT[i_val];

endmodule

// File: rtl/hex_scan.sv
// Time-multiplexed hex display driver: per-digit storage, slot scan with
// brightness PWM, leading-zero suppression and registered polarity-corrected outputs.
module hex_scan
  import hex_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned PRESCALE    = 1024,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          AN_ACT_LOW  = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [$clog2(DIGITS)-1:0]  dig,
  input  logic [3:0]                 val,
  input  logic                       dp,
  input  logic                       blank,
  input  logic                       lz_en,
  input  logic [3:0]                 bright,
  output logic [6:0]                 seg,
  output logic                       seg_dp,
  output logic [DIGITS-1:0]          an,
  output logic                       frame
);

  localparam int unsigned DIG_W   = $clog2(DIGITS);
  localparam int unsigned SUB_LEN = PRESCALE / 16;
  localparam int unsigned SUB_W   = $clog2(SUB_LEN);
  localparam bit          DIG_FULL = ((1 << DIG_W) == DIGITS);

  localparam logic [6:0]        SEG_IDLE = SEG_ACT_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic              DP_IDLE  = SEG_ACT_LOW;
  localparam logic [DIGITS-1:0] AN_IDLE  = {DIGITS{AN_ACT_LOW}};

  logic [SUB_W-1:0]  r_sub;
  logic [3:0]        r_phase;
  logic [DIG_W-1:0]  r_ptr;
  dig_rec_t          r_digits [DIGITS];
  logic [6:0]        r_seg;
  logic              r_seg_dp;
  logic [DIGITS-1:0] r_an;
  logic              r_frame;

  logic              w_sub_end;
  logic              w_slot_end;
  logic              w_wrap;
  logic              w_dig_ok;
  logic              w_wr;
  dig_rec_t          w_rec;
  logic [6:0]        w_font;
  logic [DIGITS-1:0] w_supp;
  logic              w_above_dark;
  logic [6:0]        w_seg;
  logic              w_dp;
  logic [DIGITS-1:0] w_an;

  // Slot counter split into sub-phase (0..15) and ticks within a sub-phase.
  assign w_sub_end  = (r_sub == SUB_W'(SUB_LEN - 1));
  assign w_slot_end = w_sub_end && (r_phase == 4'd15);
  assign w_wrap     = (r_ptr == DIG_W'(DIGITS - 1));

  if (DIG_FULL) begin : g_dig_full
    assign w_dig_ok = 1'b1;
  end else begin : g_dig_part
    assign w_dig_ok = (32'(dig) < DIGITS);
  end

  assign w_wr = en && w_dig_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub   <= '0;
      r_phase <= '0;
      r_ptr   <= '0;
    end else begin
      if (w_sub_end) begin
        r_sub   <= '0;
        r_phase <= r_phase + 4'd1;
      end else begin
        r_sub <= r_sub + SUB_W'(1);
      end
      if (w_slot_end) begin
        r_ptr <= w_wrap ? '0 : r_ptr + DIG_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        r_digits[i] <= '{blank: 1'b1, dp: 1'b0, val: 4'd0};
      end
    end else if (w_wr) begin
      r_digits[dig] <= '{blank: blank, dp: dp, val: val};
    end
  end

  // A digit is a leading zero when it and everything above it is zero or blank.
  always_comb begin
    w_supp       = '0;
    w_above_dark = 1'b1;
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      w_supp[i]    = lz_en && w_above_dark && (r_digits[i].val == 4'd0) && !r_digits[i].dp;
      w_above_dark = w_supp[i] || r_digits[i].blank;
    end
  end

  assign w_rec = r_digits[r_ptr];

  hex_font u_font (
    .i_val   (w_rec.val),
    .o_seg_c (w_font)
  );

  always_comb begin
    w_seg = SEG_OFF;
    w_dp  = 1'b0;
    w_an  = '0;
    if (!w_rec.blank) begin
      w_dp = w_rec.dp;
      if (!w_supp[r_ptr]) begin
        w_seg = w_font;
      end
      if (r_phase < bright) begin
        w_an[r_ptr] = 1'b1;
      end
    end
  end

  // Polarity is applied only here so all internal logic stays active-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg    <= SEG_IDLE;
      r_seg_dp <= DP_IDLE;
      r_an     <= AN_IDLE;
      r_frame  <= 1'b0;
    end else begin
      r_seg    <= SEG_ACT_LOW ? ~w_seg : w_seg;
      r_seg_dp <= w_dp ^ SEG_ACT_LOW;
      r_an     <= AN_ACT_LOW ? ~w_an : w_an;
      r_frame  <= w_slot_end && w_wrap;
    end
  end

  assign seg    = r_seg;
  assign seg_dp = r_seg_dp;
  assign an     = r_an;
  assign frame  = r_frame;

endmodule

// File: tb/tb_hex_scan.sv
// Bench for hex_scan: cycle-by-cycle behavioural model plus directed literal checks.
module tb_hex_scan;

  localparam int D = 4;
  localparam int P = 32;
  localparam int F = D * P;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] dig = 2'd0;
  logic [3:0] val = 4'd0;
  logic       dp = 1'b0;
  logic       blank = 1'b0;
  logic       lz_en = 1'b0;
  logic [3:0] bright = 4'd15;
  logic [6:0] seg;
  logic       seg_dp;
  logic [3:0] an;
  logic       frame;

  logic       en5 = 1'b0;
  logic [2:0] dig5 = 3'd0;
  logic [6:0] seg5;
  logic       seg_dp5;
  logic [4:0] an5;
  logic       frame5;

  int n_checks = 0;
  int n_fail   = 0;
  bit mdl_on   = 1'b0;

  logic [3:0] m_val   [D];
  logic       m_dp    [D];
  logic       m_blank [D];
  int         m_k;
  logic [6:0] e_seg;
  logic       e_dp;
  logic [3:0] e_an;
  logic       e_frame;

  always #5 clk = ~clk;

  hex_scan #(.DIGITS(4), .PRESCALE(32), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dig(dig), .val(val), .dp(dp), .blank(blank),
    .lz_en(lz_en), .bright(bright), .seg(seg), .seg_dp(seg_dp), .an(an), .frame(frame)
  );

  hex_scan #(.DIGITS(5), .PRESCALE(32), .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)) dut5 (
    .clk(clk), .rst_n(rst_n), .en(en5), .dig(dig5), .val(val), .dp(dp), .blank(blank),
    .lz_en(lz_en), .bright(bright), .seg(seg5), .seg_dp(seg_dp5), .an(an5), .frame(frame5)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  function automatic logic [6:0] font_hi(input logic [3:0] v);
    case (v)
      4'h0: return 7'b0111111;
      4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;
      4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;
      4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;
      4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;
      4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;
      4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;
      default: return 7'b1110001;
    endcase
  endfunction

  // Digit d is hidden when it and every digit above it is zero-without-dp or blank.
  function automatic bit suppressed(input int d);
    if (!lz_en || d == 0) return 1'b0;
    for (int j = d; j < D; j++) begin
      if (!m_blank[j] && (m_val[j] != 4'd0 || m_dp[j])) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [3:0] exp_an(input int k);
    int pos = k % F;
    int d   = pos / P;
    int c   = pos % P;
    logic [3:0] a = 4'hF;
    if (!m_blank[d] && (c / (P / 16)) < int'(bright)) a[d] = 1'b0;
    return a;
  endfunction

  function automatic logic [6:0] exp_seg(input int k);
    int d = (k % F) / P;
    if (m_blank[d] || suppressed(d)) return 7'h7F;
    return ~font_hi(m_val[d]);
  endfunction

  function automatic logic exp_dp(input int k);
    int d = (k % F) / P;
    if (m_blank[d]) return 1'b1;
    return ~m_dp[d];
  endfunction

  // Model: m_k counts clock edges since reset release; outputs lag state by one edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k <= 0;
      for (int j = 0; j < D; j++) begin
        m_val[j]   <= 4'd0;
        m_dp[j]    <= 1'b0;
        m_blank[j] <= 1'b1;
      end
      e_seg   <= 7'h7F;
      e_dp    <= 1'b1;
      e_an    <= 4'hF;
      e_frame <= 1'b0;
    end else begin
      e_an    <= exp_an(m_k);
      e_seg   <= exp_seg(m_k);
      e_dp    <= exp_dp(m_k);
      e_frame <= ((m_k + 1) % F == 0);
      m_k     <= m_k + 1;
      if (en) begin
        m_val[dig]   <= val;
        m_dp[dig]    <= dp;
        m_blank[dig] <= blank;
      end
    end
  end

  always @(negedge clk) begin
    if (mdl_on) begin
      chk("model_an", 32'(an), 32'(e_an));
      chk("model_seg", 32'(seg), 32'(e_seg));
      chk("model_dp", 32'(seg_dp), 32'(e_dp));
      chk("model_frame", 32'(frame), 32'(e_frame));
    end
  end

  task automatic wr(input int d, input logic [3:0] v, input logic p, input logic b);
    @(negedge clk);
    en = 1'b1; dig = 2'(d); val = v; dp = p; blank = b;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic wait_frame();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!frame && t < 300);
    chk("frame_seen", 32'(frame), 32'd1);
  endtask

  initial begin
    int cnt_a;
    int cnt_b;
    int cnt_d [D];

    repeat (3) @(negedge clk);
    mdl_on = 1'b1;
    chk("rst_an", 32'(an), 32'h0F);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(seg_dp), 32'd1);
    chk("rst_frame", 32'(frame), 32'd0);
    rst_n = 1'b1;

    // Idle scan: dark display, frame every F cycles.
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 4 * F; i++) begin
      @(negedge clk);
      cnt_a += int'(frame);
      if (an != 4'hF || seg != 7'h7F || seg_dp != 1'b1) cnt_b++;
    end
    chk("idle_frames", 32'(cnt_a), 32'd4);
    chk("idle_dark", 32'(cnt_b), 32'd0);

    // Digits 1,2,3,4 at full brightness.
    wr(0, 4'h1, 1'b0, 1'b0);
    wr(1, 4'h2, 1'b0, 1'b0);
    wr(2, 4'h3, 1'b0, 1'b0);
    wr(3, 4'h4, 1'b0, 1'b0);
    wait_frame();
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      chk("d0_seg", 32'(seg), 32'(7'b1111001));
      chk("d0_an", 32'(an), (i < 30) ? 32'(4'b1110) : 32'(4'b1111));
    end

    // Leading-zero suppression on 0,0,0.,5.
    wr(3, 4'h0, 1'b0, 1'b0);
    wr(2, 4'h0, 1'b0, 1'b0);
    wr(1, 4'h0, 1'b1, 1'b0);
    wr(0, 4'h5, 1'b0, 1'b0);
    lz_en = 1'b1;
    wait_frame();
    for (int i = 0; i < F; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("lz_d0_an", 32'(an), 32'(4'b1110));
        chk("lz_d0_seg", 32'(seg), 32'(7'b0010010));
        chk("lz_d0_dp", 32'(seg_dp), 32'd1);
      end else if (i == P) begin
        chk("lz_d1_seg", 32'(seg), 32'(7'b1000000));
        chk("lz_d1_dp", 32'(seg_dp), 32'd0);
      end else if (i == 2 * P || i == 3 * P) begin
        chk("lz_hi_seg", 32'(seg), 32'h7F);
        chk("lz_hi_dp", 32'(seg_dp), 32'd1);
      end
    end
    lz_en = 1'b0;

    // Brightness extremes.
    bright = 4'd0;
    cnt_a = 0;
    for (int i = 0; i < F; i++) begin
      @(negedge clk);
      if (an != 4'hF) cnt_a++;
    end
    chk("bright0_an", 32'(cnt_a), 32'd0);
    bright = 4'd8;
    @(negedge clk);
    for (int j = 0; j < D; j++) cnt_d[j] = 0;
    for (int i = 0; i < F; i++) begin
      @(negedge clk);
      for (int j = 0; j < D; j++) if (!an[j]) cnt_d[j]++;
    end
    for (int j = 0; j < D; j++) chk("bright8_on", 32'(cnt_d[j]), 32'd16);
    bright = 4'd15;

    // Write to digit 2 while it is on display.
    wait_frame();
    repeat (2 * P + 5) @(negedge clk);
    en = 1'b1; dig = 2'd2; val = 4'hF; dp = 1'b0; blank = 1'b0;
    @(negedge clk);
    en = 1'b0;
    chk("live_wr_old", 32'(seg), 32'(7'b1000000));
    @(negedge clk);
    chk("live_wr_new", 32'(seg), 32'(7'b0001110));

    // Reset at slot count 17 of digit 2.
    wait_frame();
    repeat (2 * P + 17) @(negedge clk);
    chk("pre_rst_an", 32'(an), 32'(4'b1011));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_an", 32'(an), 32'h0F);
    chk("mid_rst_seg", 32'(seg), 32'h7F);
    chk("mid_rst_dp", 32'(seg_dp), 32'd1);
    chk("mid_rst_frame", 32'(frame), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1; dig = 2'd0; val = 4'h8; dp = 1'b0; blank = 1'b0;
    @(negedge clk);
    en = 1'b0;
    chk("restart_an0", 32'(an), 32'h0F);
    @(negedge clk);
    chk("restart_an1", 32'(an), 32'(4'b1110));
    chk("restart_seg", 32'(seg), 32'(7'b0000000));

    // Out-of-range digit indices on a 5-digit instance.
    @(negedge clk);
    en5 = 1'b1; dig5 = 3'd5; val = 4'h8; blank = 1'b0; dp = 1'b1;
    @(negedge clk);
    dig5 = 3'd7;
    @(negedge clk);
    en5 = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 5 * P; i++) begin
      @(negedge clk);
      if (an5 != 5'h1F || seg5 != 7'h7F || seg_dp5 != 1'b1) cnt_a++;
    end
    chk("oob_ignored", 32'(cnt_a), 32'd0);
    en5 = 1'b1; dig5 = 3'd4;
    @(negedge clk);
    en5 = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 5 * P; i++) begin
      @(negedge clk);
      if (!an5[4]) cnt_a++;
    end
    chk("d5_top_on", 32'(cnt_a), 32'd30);

    mdl_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
